// File: rtl/rect_fill.sv
// rect_fill: fills an axis-aligned rectangle of the 160x120 framebuffer with a
// single colour. It emits one pixel per cycle in column-major order: x is the
// outer loop and y the inner loop.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start               request, held high by the requester until done is seen
//   x0, y0, x1, y1      two opposite corners, in either order
//   colour              fill colour
//   done                fill finished; stays high until start drops
//   vga_x, vga_y        pixel coordinate
//   vga_colour          pixel colour
//   vga_plot            write strobe, high for each emitted pixel
//
// Handshake: the requester raises start and holds it. The block samples the
// corners and colour once, in LOAD, then plots. It raises done and keeps it
// high until it samples start low, then returns to IDLE. Dropping start early
// does not abort a fill. In that case done is still high for one cycle.
//
// Every output is registered from the current state and counters. As a
// result, the outputs trail the state register by one clock edge.
module rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] colour,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  // The state register is kept visible by name so that checkers can probe it.
  state_t     state;
  logic [7:0] cx, xhi;
  logic [6:0] cy, ylo, yhi;
  logic [2:0] col_q;

  // Order the corners and clip them to the screen. These values are used only
  // in LOAD.
  logic [7:0] xmin, xmax, xclip;
  logic [6:0] ymin, ymax, yclip;
  logic       off_screen;

  always_comb begin
    xmin       = (x0 < x1) ? x0 : x1;
    xmax       = (x0 < x1) ? x1 : x0;
    xclip      = (xmax > X_LAST) ? X_LAST : xmax;
    ymin       = (y0 < y1) ? y0 : y1;
    ymax       = (y0 < y1) ? y1 : y0;
    yclip      = (ymax > Y_LAST) ? Y_LAST : ymax;
    // If the lower corner is off screen, the whole rectangle is off screen.
    off_screen = (xmin > X_LAST) || (ymin > Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      xhi        <= '0;
      ylo        <= '0;
      yhi        <= '0;
      col_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          vga_x      <= '0;
          vga_y      <= '0;
          vga_colour <= '0;
          vga_plot   <= 1'b0;
          if (start) state <= LOAD;
        end

        LOAD: begin
          col_q <= colour;
          xhi   <= xclip;
          ylo   <= ymin;
          yhi   <= yclip;
          cx    <= xmin;
          cy    <= ymin;
          state <= off_screen ? DONE : FILL;
        end

        FILL: begin
          vga_x      <= cx;
          vga_y      <= cy;
          vga_colour <= col_q;
          vga_plot   <= 1'b1;
          if (cx == xhi && cy == yhi) begin
            state <= DONE;
          end else if (cy < yhi) begin
            cy <= cy + 7'd1;
          end else begin
            cy <= ylo;
            cx <= cx + 8'd1;
          end
        end

        DONE: begin
          vga_x      <= '0;
          vga_y      <= '0;
          vga_colour <= '0;
          vga_plot   <= 1'b0;
          // Raise done first, then release only after it has been visible.
          // This keeps done high for at least one cycle even if start
          // dropped during the fill.
          if (done && !start) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
